// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU writeback slice.
//   - ALU opcode constants
//   - bit positions of the n/z/v/c flags inside a 4-bit flag vector
//   - wb_entry_t, one buffered ALU result as held in the result queue
//   - entry_writes_reg(), tells whether an entry updates the register file
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_CNT = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_ROR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [3:0]        optcode;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
    logic [ADDR_W-1:0] rd;
    logic              set_flags;
  } wb_entry_t;

  // CMP only produces flags, and R0 is hard-wired to zero.
  function automatic logic entry_writes_reg(input wb_entry_t e);
    return (e.optcode != OP_CMP) && (e.rd != {ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry result queue.
// Entry 0 is always the head. Both entries are exposed so that the parent
// can compare every queued destination against its read addresses.
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i       : write push_data_i (caller guarantees count_o < 2)
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head (caller guarantees count_o > 0)
//   count_o      : number of valid entries (0..2)
//   entry0_o     : head entry (valid when count_o >= 1)
//   entry1_o     : second entry (valid when count_o == 2)
module wb_fifo2
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output logic [1:0] count_o,
  output wb_entry_t entry0_o,
  output wb_entry_t entry1_o
);

  wb_entry_t  slot0_q, slot0_d;
  wb_entry_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;

  // Next-state for the shift-style queue: a pop moves slot 1 into the head.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data_i;
        end else begin
          slot1_d = push_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count stays put; the new entry lands behind whatever remains.
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign entry0_o = slot0_q;
  assign entry1_o = slot1_q;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: execute-to-writeback stage behind the ALU.
// ALU results are queued (2 deep) and retired into a 16x32 register file
// and a 4-bit NZVC status register. An external (load) write owns the
// register-file port whenever it is requested, stalling retirement.
//   in_*                : ALU result handshake and payload
//   ext_wr_*            : external write port (priority)
//   rd_addr_x/rd_data_x : combinational operand reads with write bypass
//   hazard_x            : read address has a pending queued write
//   status_nzvc         : architectural flags {n,z,v,c}
//   wb_valid/wb_rd/wb_data : registered pulse describing the last retire
module alu_writeback
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_optcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_set_flags,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [3:0]        status_nzvc,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic [3:0]        status_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  wb_entry_t  push_entry, head, second;
  logic [1:0] count;
  logic       push, retire, head_we, ext_we;
  logic       rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Ready depends on occupancy only, so a full queue never pushes even if
  // it is about to retire.
  assign in_ready = (count < 2'd2);
  assign push     = in_valid && in_ready;
  assign retire   = (count != 2'd0) && !ext_wr_en;
  assign head_we  = retire && entry_writes_reg(head);
  assign ext_we   = ext_wr_en && (ext_wr_addr != {ADDR_W{1'b0}});

  assign push_entry = '{optcode: in_optcode, result: in_result, flags: in_flags,
                        rd: in_rd, set_flags: in_set_flags};

  wb_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (retire),
    .count_o     (count),
    .entry0_o    (head),
    .entry1_o    (second)
  );

  // Register-file write port arbitration: external write first.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = {ADDR_W{1'b0}};
    rf_wdata = {DATA_W{1'b0}};
    if (ext_we) begin
      rf_we    = 1'b1;
      rf_waddr = ext_wr_addr;
      rf_wdata = ext_wr_data;
    end else if (head_we) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.result;
    end else begin
      rf_we    = 1'b0;
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end else begin
      rf_q[0] <= {DATA_W{1'b0}};
    end
  end

  // Status flags and the registered writeback pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q   <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= {ADDR_W{1'b0}};
      wb_data_q  <= {DATA_W{1'b0}};
    end else if (retire) begin
      if (head.set_flags || (head.optcode == OP_CMP)) begin
        status_q <= head.flags;
      end else begin
        status_q <= status_q;
      end
      wb_valid_q <= 1'b1;
      wb_rd_q    <= head.rd;
      wb_data_q  <= head.result;
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  // Operand port A: zero for R0, then ext write, then retiring head, then array.
  always_comb begin
    if (rd_addr_a == {ADDR_W{1'b0}}) begin
      rd_data_a = {DATA_W{1'b0}};
    end else if (ext_wr_en && (ext_wr_addr == rd_addr_a)) begin
      rd_data_a = ext_wr_data;
    end else if (head_we && (head.rd == rd_addr_a)) begin
      rd_data_a = head.result;
    end else begin
      rd_data_a = rf_q[rd_addr_a];
    end
  end

  // Operand port B: same priority as port A.
  always_comb begin
    if (rd_addr_b == {ADDR_W{1'b0}}) begin
      rd_data_b = {DATA_W{1'b0}};
    end else if (ext_wr_en && (ext_wr_addr == rd_addr_b)) begin
      rd_data_b = ext_wr_data;
    end else if (head_we && (head.rd == rd_addr_b)) begin
      rd_data_b = head.result;
    end else begin
      rd_data_b = rf_q[rd_addr_b];
    end
  end

  // Hazards: the head counts only while it is not retiring; the second
  // entry can never retire in the current cycle.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    if ((count != 2'd0) && !retire && entry_writes_reg(head)) begin
      hazard_a = (head.rd == rd_addr_a);
      hazard_b = (head.rd == rd_addr_b);
    end else begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
    end
    if ((count == 2'd2) && entry_writes_reg(second)) begin
      hazard_a = hazard_a || (second.rd == rd_addr_a);
      hazard_b = hazard_b || (second.rd == rd_addr_b);
    end else begin
      hazard_a = hazard_a;
      hazard_b = hazard_b;
    end
  end

  assign status_nzvc = status_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;

endmodule
